// File: rtl/pipeline_ctrl.sv
// Sequencing controller for a 5-stage RV32I pipeline: stage loads/flushes, hazard
// resolution, debug halt/single-step FSM and stall/retire performance counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_br_taken,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted, StStep} state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e state_q, state_d;
    logic   v_id_q, v_id_d;
    logic   v_ex_q, v_ex_d;
    logic   v_mem_q, v_mem_d;
    logic   v_wb_q, v_wb_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    logic stall_mem;
    logic load_use;
    logic redirect;
    logic if_valid;
    logic pipe_empty;
    logic rs1_hit;
    logic rs2_hit;

    assign stall_mem  = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);
    assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use   = v_id_q & v_ex_q & ex_is_load & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    assign redirect   = v_ex_q & ex_br_taken;
    assign if_valid   = (state_q == StRun) | (state_q == StStep);
    assign pipe_empty = ~(v_id_q | v_ex_q | v_mem_q | v_wb_q);

    // Stage load/flush decode; everything is forced low while reset is asserted.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = (state_q == StHalted);
        if (rst && state_q != StHalted) begin
            if (stall_mem) begin
                load_pc = 1'b0;
            end else if (redirect) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                load_id_ex  = 1'b1;
                flush_id_ex = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
            // Draining: stop fetching but let a redirect keep the PC correct.
            if (state_q == StDrain) begin
                if (!redirect) begin
                    load_pc = 1'b0;
                end
                flush_if_id = load_if_id;
            end
        end
    end

    always_comb begin
        v_id_d  = v_id_q;
        v_ex_d  = v_ex_q;
        v_mem_d = v_mem_q;
        v_wb_d  = v_wb_q;
        if (load_if_id) begin
            v_id_d = if_valid & ~flush_if_id;
        end
        if (load_id_ex) begin
            v_ex_d = v_id_q & ~flush_id_ex;
        end
        if (load_ex_mem) begin
            v_mem_d = v_ex_q;
        end
        if (load_mem_wb) begin
            v_wb_d = v_mem_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (halt_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!halt_req) begin
                    state_d = StRun;
                end else if (pipe_empty) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (step_req) begin
                    state_d = StStep;
                end else if (!halt_req) begin
                    state_d = StRun;
                end
            end
            StStep: begin
                // Stay until the single fetch actually advances past any memory wait.
                if (load_pc) begin
                    state_d = StDrain;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (state_q != StHalted && (stall_mem || load_use) && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (load_mem_wb && v_mem_q && !stall_mem && retire_cnt_q != CntMax) begin
            retire_cnt_d = retire_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RESET_HALTED ? StHalted : StRun;
            v_id_q       <= 1'b0;
            v_ex_q       <= 1'b0;
            v_mem_q      <= 1'b0;
            v_wb_q       <= 1'b0;
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            v_id_q       <= v_id_d;
            v_ex_q       <= v_ex_d;
            v_mem_q      <= v_mem_d;
            v_wb_q       <= v_wb_d;
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule
